test_pattern_gen: RTL and testbench

Pixel-source stage directly downstream of the sync/position generator. Consumes the per-pixel screen position (`sx`, `sy`) and the registered `hsync`/`vsync`/`de` from that generator. Produces a 24-bit RGB stream with sync and data-enable re-aligned to it, ready for the TMDS encoder. Provides four selectable test patterns, including a per-frame animated bouncing box, for bring-up of the HDMI path without a frame buffer.

---
 rtl/test_pattern_gen_if.sv | 26 ++
 rtl/test_pattern_gen.sv | 194 +++++++++++++++++++
 tb/tb_test_pattern_gen.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/test_pattern_gen_if.sv
// Pixel bus between the sync/position generator, the pattern source and the TMDS encoder.
// master drives position/syncs/mode and receives the pixel; slave is the pattern source.
interface test_pattern_gen_if;
    logic        pix_en;
    logic [11:0] sx;
    logic [11:0] sy;
    logic        hsync_in;
    logic        vsync_in;
    logic        de_in;
    logic [1:0]  mode;
    logic [23:0] rgb;
    logic        hsync_out;
    logic        vsync_out;
    logic        de_out;
    logic [7:0]  frame_cnt;

    modport master (
        output pix_en, sx, sy, hsync_in, vsync_in, de_in, mode,
        input  rgb, hsync_out, vsync_out, de_out, frame_cnt
    );

    modport slave (
        input  pix_en, sx, sy, hsync_in, vsync_in, de_in, mode,
        output rgb, hsync_out, vsync_out, de_out, frame_cnt
    );
endinterface

// File: rtl/test_pattern_gen.sv
// Bars/checker/bouncing-box/gradient pixel source; defining TPG_BORDER_EN adds a white frame border.
// Latency: rgb 2 enabled cycles after sx/sy, syncs 1; no backpressure, pix_en=0 holds every register.
module test_pattern_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int BOX_SIZE    = 32,
    parameter int CHECK_SHIFT = 5
) (
    input  logic              clk_pix,
    input  logic              reset,
    test_pattern_gen_if.slave bus
);
    localparam logic [11:0] H_ACT = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT = 12'(V_ACTIVE);
    localparam logic [11:0] BOX_W = 12'(BOX_SIZE);
    localparam logic [11:0] BAR_W = 12'(H_ACTIVE / 8);
    localparam logic [11:0] X_LIM = 12'(H_ACTIVE - BOX_SIZE);
    localparam logic [11:0] Y_LIM = 12'(V_ACTIVE - BOX_SIZE);

    localparam logic [23:0] C_WHITE = 24'hFFFFFF;
    localparam logic [23:0] C_BLACK = 24'h000000;
    localparam logic [23:0] C_BOX   = 24'hFF0000;
    localparam logic [23:0] C_BACK  = 24'h202020;

    // stage 1: pattern terms
    logic        s1_active_q, s1_active_d;
    logic [2:0]  s1_bar_q,    s1_bar_d;
    logic        s1_check_q,  s1_check_d;
    logic        s1_in_box_q, s1_in_box_d;
    logic [23:0] s1_grad_q,   s1_grad_d;
`ifdef TPG_BORDER_EN
    logic        s1_border_q, s1_border_d;
`endif

    // stage 2 / outputs
    logic [23:0] rgb_q,   rgb_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        de_q,    de_d;

    // per-frame state
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [1:0]  mode_q,      mode_d;
    logic [11:0] box_x_q,     box_x_d;
    logic [11:0] box_y_q,     box_y_d;
    logic        dir_x_q,     dir_x_d;
    logic        dir_y_q,     dir_y_d;

    logic        tick;
    logic [23:0] pat;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return 24'hFFFFFF;
            3'd1:    return 24'hFFFF00;
            3'd2:    return 24'h00FFFF;
            3'd3:    return 24'h00FF00;
            3'd4:    return 24'hFF00FF;
            3'd5:    return 24'hFF0000;
            3'd6:    return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Returns {dir, pos}: a step at the limit reverses and moves back one in the same tick.
    function automatic logic [12:0] bounce_step(input logic [11:0] pos, input logic dir,
                                                input logic [11:0] lim);
        if (dir) begin
            if (pos == lim) return {1'b0, pos - 12'd1};
            return {1'b1, pos + 12'd1};
        end
        if (pos == 12'd0) return {1'b1, 12'd1};
        return {1'b0, pos - 12'd1};
    endfunction

    assign tick = bus.pix_en && (bus.sx == 12'd0) && (bus.sy == V_ACT);

    always_comb begin
        s1_active_d = s1_active_q;
        s1_bar_d    = s1_bar_q;
        s1_check_d  = s1_check_q;
        s1_in_box_d = s1_in_box_q;
        s1_grad_d   = s1_grad_q;
`ifdef TPG_BORDER_EN
        s1_border_d = s1_border_q;
`endif
        if (bus.pix_en) begin
            s1_active_d = (bus.sx < H_ACT) && (bus.sy < V_ACT);
            // bar index by comparison against constant multiples of the bar width
            s1_bar_d = 3'd0;
            for (int i = 1; i < 8; i++) begin
                if (bus.sx >= BAR_W * 12'(i)) s1_bar_d = 3'(i);
            end
            s1_check_d  = bus.sx[CHECK_SHIFT] ^ bus.sy[CHECK_SHIFT];
            s1_in_box_d = (bus.sx >= box_x_q) && (bus.sx < box_x_q + BOX_W) &&
                          (bus.sy >= box_y_q) && (bus.sy < box_y_q + BOX_W);
            s1_grad_d   = {bus.sx[7:0], bus.sy[7:0], frame_cnt_q};
`ifdef TPG_BORDER_EN
            s1_border_d = (bus.sx == 12'd0) || (bus.sx == H_ACT - 12'd1) ||
                          (bus.sy == 12'd0) || (bus.sy == V_ACT - 12'd1);
`endif
        end
    end

    always_comb begin
        pat = C_BLACK;
        case (mode_q)
            2'd0:    pat = bar_colour(s1_bar_q);
            2'd1:    pat = s1_check_q ? C_WHITE : C_BLACK;
            2'd2:    pat = s1_in_box_q ? C_BOX : C_BACK;
            default: pat = s1_grad_q;
        endcase
`ifdef TPG_BORDER_EN
        if (s1_border_q) pat = C_WHITE;
`endif
    end

    always_comb begin
        rgb_d   = rgb_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        de_d    = de_q;
        if (bus.pix_en) begin
            rgb_d   = s1_active_q ? pat : C_BLACK;
            // syncs already lag sx/sy by one cycle upstream, so one stage aligns them with rgb
            hsync_d = bus.hsync_in;
            vsync_d = bus.vsync_in;
            de_d    = bus.de_in;
        end
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        mode_d      = mode_q;
        box_x_d     = box_x_q;
        box_y_d     = box_y_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        if (tick) begin
            frame_cnt_d        = frame_cnt_q + 8'd1;
            mode_d             = bus.mode;
            {dir_x_d, box_x_d} = bounce_step(box_x_q, dir_x_q, X_LIM);
            {dir_y_d, box_y_d} = bounce_step(box_y_q, dir_y_q, Y_LIM);
        end
    end

    always_ff @(posedge clk_pix) begin
        if (!reset) begin
            s1_active_q <= 1'b0;
            s1_bar_q    <= 3'd0;
            s1_check_q  <= 1'b0;
            s1_in_box_q <= 1'b0;
            s1_grad_q   <= 24'd0;
`ifdef TPG_BORDER_EN
            s1_border_q <= 1'b0;
`endif
            rgb_q       <= 24'd0;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            de_q        <= 1'b0;
            frame_cnt_q <= 8'd0;
            mode_q      <= 2'd0;
            box_x_q     <= 12'd0;
            box_y_q     <= 12'd0;
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b1;
        end else begin
            s1_active_q <= s1_active_d;
            s1_bar_q    <= s1_bar_d;
            s1_check_q  <= s1_check_d;
            s1_in_box_q <= s1_in_box_d;
            s1_grad_q   <= s1_grad_d;
`ifdef TPG_BORDER_EN
            s1_border_q <= s1_border_d;
`endif
            rgb_q       <= rgb_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            de_q        <= de_d;
            frame_cnt_q <= frame_cnt_d;
            mode_q      <= mode_d;
            box_x_q     <= box_x_d;
            box_y_q     <= box_y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
        end
    end

    assign bus.rgb       = rgb_q;
    assign bus.hsync_out = hsync_q;
    assign bus.vsync_out = vsync_q;
    assign bus.de_out    = de_q;
    assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_test_pattern_gen.sv
// Randomised scoreboard bench for test_pattern_gen against a closed-form pattern/box model.
`timescale 1ns/1ps
module tb_test_pattern_gen;
    localparam int H   = 640;
    localparam int V   = 480;
    localparam int BOX = 32;
    localparam int CS  = 5;

    logic clk_pix = 1'b0;
    logic reset   = 1'b0;

    test_pattern_gen_if bus ();

    test_pattern_gen #(
        .H_ACTIVE(H), .V_ACTIVE(V), .BOX_SIZE(BOX), .CHECK_SHIFT(CS)
    ) dut (
        .clk_pix (clk_pix),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_pix = ~clk_pix;

    typedef struct packed {
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        de;
        logic [7:0]  fc;
    } obs_t;

    obs_t  exp_q [$];
    int    vectors     = 0;
    int    miscompares = 0;
    string phase       = "reset";

    // reference model state
    int          ticks     = 0;
    int          fc        = 0;
    int          mode_m    = 0;
    logic [23:0] prev_col  = '0;
    logic [2:0]  prev_sync = '0;

    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    int scan_rows [8] = '{0, 1, 239, 478, 479, 480, 481, 524};

    // Box position after n ticks: triangle wave between 0 and lim.
    function automatic int tri_pos(input int n, input int lim);
        int p;
        p = n % (2 * lim);
        return (p <= lim) ? p : 2 * lim - p;
    endfunction

    function automatic logic [23:0] colour(input int x, input int y, input int md,
                                           input int tk, input int f);
        int bx, by;
        if (x >= H || y >= V) return 24'h0;
`ifdef TPG_BORDER_EN
        if (x == 0 || x == H - 1 || y == 0 || y == V - 1) return 24'hFFFFFF;
`endif
        case (md)
            0: return bar_tab[x / (H / 8)];
            1: return ((((x >> CS) ^ (y >> CS)) & 1) == 1) ? 24'hFFFFFF : 24'h0;
            2: begin
                bx = tri_pos(tk, H - BOX);
                by = tri_pos(tk, V - BOX);
                return (x >= bx && x < bx + BOX && y >= by && y < by + BOX) ? 24'hFF0000 : 24'h202020;
            end
            default: return {x[7:0], y[7:0], f[7:0]};
        endcase
    endfunction

    function automatic logic [2:0] sync_of(input int x, input int y);
        return {(x >= 656 && x < 752), (y >= 490 && y < 492), (x < H && y < V)};
    endfunction

    task automatic check(input obs_t e, input string what);
        obs_t a;
        a = {bus.rgb, bus.hsync_out, bus.vsync_out, bus.de_out, bus.frame_cnt};
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s/%s t=%0t: got rgb=%06h hs=%0b vs=%0b de=%0b fc=%0d, want rgb=%06h hs=%0b vs=%0b de=%0b fc=%0d",
                     phase, what, $time, a.rgb, a.hs, a.vs, a.de, a.fc, e.rgb, e.hs, e.vs, e.de, e.fc);
        end
    endtask

    // One clock of stimulus; an enabled edge pushes the output expected right after it.
    task automatic apply(input int x, input int y, input int m, input bit en);
        obs_t        e;
        logic [23:0] col;
        bus.sx     = 12'(x);
        bus.sy     = 12'(y);
        bus.mode   = 2'(m);
        bus.pix_en = en;
        if (en) {bus.hsync_in, bus.vsync_in, bus.de_in} = prev_sync;
        else    {bus.hsync_in, bus.vsync_in, bus.de_in} = 3'($urandom_range(0, 7));
        @(posedge clk_pix);
        if (en && reset) begin
            col = colour(x, y, mode_m, ticks, fc);
            if (x == 0 && y == V) begin
                fc     = (fc + 1) % 256;
                mode_m = m;
                ticks++;
            end
            e.rgb = prev_col;
            {e.hs, e.vs, e.de} = prev_sync;
            e.fc  = 8'(fc);
            exp_q.push_back(e);
            prev_col  = col;
            prev_sync = sync_of(x, y);
        end
        #1;
    endtask

    task automatic stall();
        if ($urandom_range(0, 3) == 0) apply(0, V, int'($urandom_range(0, 3)), 1'b0);
        else apply(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)),
                   int'($urandom_range(0, 3)), 1'b0);
    endtask

    task automatic pix(input int x, input int y, input int m);
        if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 3)) stall();
        apply(x, y, m, 1'b1);
    endtask

    task automatic rand_pix(input int m);
        pix(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)), m);
    endtask

    task automatic do_reset(input int n, input bit en_rand);
        reset = 1'b0;
        repeat (n) begin
            bus.pix_en = en_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.sx     = 12'($urandom_range(0, 799));
            bus.sy     = 12'($urandom_range(0, 524));
            {bus.hsync_in, bus.vsync_in, bus.de_in} = 3'($urandom_range(0, 7));
            @(posedge clk_pix);
            #1;
        end
        reset     = 1'b1;
        ticks     = 0;
        fc        = 0;
        mode_m    = 0;
        prev_col  = '0;
        prev_sync = '0;
    endtask

    task automatic box_pixels();
        int bx, by;
        bx = tri_pos(ticks, H - BOX);
        by = tri_pos(ticks, V - BOX);
        pix(bx, by, 2);
        pix(bx + BOX, by, 2);
        if (bx > 0) pix(bx - 1, by, 2);
        pix(bx + BOX - 1, by + BOX - 1, 2);
        pix(bx, by + BOX, 2);
        pix(bx + BOX / 2, by + BOX / 2, 2);
    endtask

    // Monitor: pops one expectation per enabled edge, checks holds on stalled edges.
    initial begin : monitor
        obs_t last;
        obs_t e;
        logic r;
        logic en;
        last = '0;
        forever begin
            @(posedge clk_pix);
            r  = reset;
            en = bus.pix_en;
            @(negedge clk_pix);
            if (!r) begin
                check('0, "reset");
                last = '0;
                exp_q.delete();
            end else if (en) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL %s/underflow t=%0t: output edge with no expectation queued", phase, $time);
                end else begin
                    e = exp_q.pop_front();
                    check(e, "pixel");
                    last = e;
                end
            end else begin
                check(last, "hold");
            end
        end
    end

    initial begin
        bus.pix_en = 1'b1;
        bus.sx = '0; bus.sy = '0; bus.mode = '0;
        bus.hsync_in = 1'b0; bus.vsync_in = 1'b0; bus.de_in = 1'b0;
        do_reset(3, 1'b0);

        phase = "bars";
        pix(0, V, 0);
        pix(80, 10, 0);
        pix(639, 10, 0);
        repeat (40) rand_pix(0);

        phase = "grad";
        repeat (4) pix(0, V, 3);
        pix(300, 200, 3);
        pix(700, 10, 3);
        repeat (30) rand_pix(3);

        phase = "bounce";
        while (ticks < 608) pix(0, V, 2);
        box_pixels();
        pix(0, V, 2);
        box_pixels();
        repeat (20) rand_pix(2);

        phase = "modechg";
        pix(0, V, 1);
        for (int y = 98; y <= 102; y++)
            for (int k = 0; k < 6; k++)
                pix(int'($urandom_range(0, H - 1)), y, (y >= 100) ? 2 : 1);
        phase = "stall";
        repeat (10) stall();
        pix(0, V, 2);
        repeat (10) pix(int'($urandom_range(0, H - 1)), int'($urandom_range(0, V - 1)), 2);

        phase = "scan";
        for (int r = 0; r < 8; r++)
            for (int x = 0; x < 800; x++)
                pix(x, scan_rows[r], 3);

        phase = "random";
        for (int i = 0; i < 300; i++) begin
            if (i == 150) do_reset(2, 1'b1);
            if ($urandom_range(0, 9) == 0) pix(0, V, int'($urandom_range(0, 3)));
            else rand_pix(int'($urandom_range(0, 3)));
        end

        phase = "border";
        pix(0, V, 1);
        pix(0, 5, 1);
        pix(639, 5, 1);
        pix(5, 0, 1);
        pix(5, 479, 1);
        pix(1, 1, 1);
        pix(33, 2, 1);

        phase = "drain";
        repeat (2) apply(0, 0, 0, 1'b0);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
